uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
- REQ-001: Parameter ADDR_WIDTH, default 9; log2 of storage depth (DEPTH = 512 bytes).
- REQ-002: Parameter DATA_WIDTH, default 8; byte width.
- REQ-003: CLK  input  1  single clock; all logic is rising-edge, except the RAM read port, which samples on the falling edge.
- REQ-004: RST  input  1  reset, synchronous and active-high.
- REQ-005: WR_DATA  input  DATA_WIDTH  byte from UART receiver.
- REQ-006: WR_VALID  input  1  WR_DATA valid this cycle.
- REQ-007: WR_READY  output  1  high when storage not full.
- REQ-008: RD_DATA  output  DATA_WIDTH  byte to UART transmitter.
- REQ-009: RD_VALID  output  1  RD_DATA holds an unconsumed byte.
- REQ-010: RD_READY  input  1  transmitter consumes RD_DATA.
- REQ-011: LEVEL  output  ADDR_WIDTH+1  bytes stored in RAM, excluding the output register.
- REQ-012: OVERFLOW  output  1  sticky; a write was attempted while full.
- REQ-013: CLR_OVF  input  1  clears OVERFLOW.

Function
- REQ-014: Write accept = WR_VALID & WR_READY; the byte is written to RAM[wr_ptr] on that edge and wr_ptr increments.
- REQ-015: WR_READY = (LEVEL != DEPTH), combinational from registered LEVEL.
- REQ-016: Pointers are ADDR_WIDTH bits wide and wrap modulo DEPTH (511 -> 0).
- REQ-017: The read FSM has three states: IDLE, FETCH and HOLD.
  - IDLE -> FETCH when LEVEL > 0.
  - FETCH -> HOLD unconditionally. On that edge the FSM captures RAM output into RD_DATA, sets RD_VALID and increments rd_ptr.
  - HOLD -> IDLE when RD_READY; RD_VALID clears on that edge.
- REQ-018: RAM read address = rd_ptr (registered). It is stable for the whole FETCH cycle so the falling-edge read is valid.
- REQ-019: LEVEL changes as follows:
  - +1 on write accept.
  - -1 on the FETCH -> HOLD edge.
  - Unchanged when both occur on the same edge.
- REQ-020: Latency: a byte accepted into an empty FIFO with the FSM in IDLE at edge E0 gives RD_VALID high after edge E2.
- REQ-021: Sustained throughput is one byte per 3 cycles when RD_READY is held high.
- REQ-022: A write while full is dropped: no RAM write, pointers and LEVEL unchanged, and OVERFLOW set on that edge.
- REQ-023: CLR_OVF clears OVERFLOW. If a dropped write and CLR_OVF coincide, the set wins.
- REQ-024: RD_DATA is held stable while RD_VALID & !RD_READY.
- REQ-025: Simultaneous write and fetch at LEVEL == DEPTH: the fetch frees a slot only after the edge, so WR_READY is low and the write is dropped.

Reset
- REQ-026: On RST, the block shall set wr_ptr = 0, rd_ptr = 0, LEVEL = 0, FSM = IDLE, RD_VALID = 0, RD_DATA = 0 and OVERFLOW = 0.
- REQ-027: RAM contents are not cleared. A reset mid-operation discards all stored bytes and any byte held in the output register.
- REQ-028: RST overrides WR_VALID, RD_READY and CLR_OVF on the same edge.

Configuration
- REQ-029: Macro UART_FIFO_WATERMARK_EN, when defined, adds output MAX_LEVEL (ADDR_WIDTH+1 bits).
  - MAX_LEVEL is the highest LEVEL since reset or CLR_OVF, updated one edge after LEVEL changes.
  - It resets to 0.
- REQ-030: When UART_FIFO_WATERMARK_EN is undefined, the port and its logic are absent; all other behaviour is identical.

Structure
- REQ-031: Shared package uart_pkg holds the FSM state encoding (IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2) and default ADDR_WIDTH/DATA_WIDTH constants.
- REQ-032: Storage is one instance of the team's existing 512x8 RAM module.
  - Its ports: CLK, WR_ADDR, DIN, WR_EN, RD_ADDR, DOUT.
  - Its timing: posedge write, negedge registered read.
  - It is the only sub-module; the controller logic is flat.

Verification
- REQ-033: Reset, then write 0x41 at E0 -> RD_VALID rises after E2 with RD_DATA = 0x41, LEVEL returns to 0, and OVERFLOW = 0.
- REQ-034: Write 512 bytes 0x00..0xFF twice with RD_READY = 0 -> LEVEL peaks at 512 (one byte moves to the output register), WR_READY = 0 at LEVEL = 512, and a further write sets OVERFLOW.
- REQ-035: With RD_READY = 1, write 600 bytes, one every 4 cycles -> read order is identical, the pointers wrap past 511, and nothing is dropped.
- REQ-036: Hold RD_VALID with RD_READY = 0 for 10 cycles -> RD_DATA is unchanged. Pulse CLR_OVF together with a dropped write -> OVERFLOW stays 1.
- REQ-037: Assert RST while LEVEL = 5 and RD_VALID = 1 -> next cycle LEVEL = 0, RD_VALID = 0, and the next written byte 0x5A is the next byte read.
- REQ-038: With UART_FIFO_WATERMARK_EN defined, write 7 bytes then drain -> MAX_LEVEL = 6 or 7 per REQ-019 and REQ-029, and it holds after the drain.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared read-FSM state encoding and default widths for uart_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_ram.sv
// ============================================================================
// Module   : uart_fifo_ram
// Brief    : Simple dual-port RAM, posedge write, negedge registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_ram #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [DATA_WIDTH-1:0] DOUT
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge CLK) begin
        if (WR_EN) begin
            mem[WR_ADDR] <= DIN;
        end
    end

    // Read on the falling edge so the data is ready for the next rising edge.
    always_ff @(negedge CLK) begin
        DOUT <= mem[RD_ADDR];
    end

endmodule

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module   : uart_fifo
// Brief    : 512-byte UART byte FIFO with registered output stage and sticky
//            overflow flag. Define UART_FIFO_WATERMARK_EN to add MAX_LEVEL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH:0]   LEVEL,
    output logic                  OVERFLOW,
    input  logic                  CLR_OVF
`ifdef UART_FIFO_WATERMARK_EN
    ,
    output logic [ADDR_WIDTH:0]   MAX_LEVEL
`endif
);

    localparam int                DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = DEPTH_INT[ADDR_WIDTH:0];

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  wr_accept;
    logic                  wr_drop;
    logic                  fetch_done;

    assign WR_READY   = (LEVEL != DEPTH);
    assign wr_accept  = WR_VALID &  WR_READY;
    assign wr_drop    = WR_VALID & ~WR_READY;
    assign fetch_done = (state == FETCH);

    uart_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .CLK     (CLK),
        .WR_ADDR (wr_ptr),
        .DIN     (WR_DATA),
        .WR_EN   (wr_accept),
        .RD_ADDR (rd_ptr),
        .DOUT    (ram_dout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LEVEL    <= '0;
            state    <= IDLE;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // A fetch and an accepted write on the same edge cancel out.
            case ({wr_accept, fetch_done})
                2'b10:   LEVEL <= LEVEL + 1'b1;
                2'b01:   LEVEL <= LEVEL - 1'b1;
                default: LEVEL <= LEVEL;
            endcase

            if (wr_drop) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_OVF) begin
                OVERFLOW <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (LEVEL != '0) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state    <= HOLD;
                    RD_DATA  <= ram_dout;
                    RD_VALID <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                end
                HOLD: begin
                    if (RD_READY) begin
                        state    <= IDLE;
                        RD_VALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_FIFO_WATERMARK_EN
    // Tracks registered LEVEL, so it lags LEVEL by one edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MAX_LEVEL <= '0;
        end else if (CLR_OVF) begin
            MAX_LEVEL <= LEVEL;
        end else if (LEVEL > MAX_LEVEL) begin
            MAX_LEVEL <= LEVEL;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo.sv
// ============================================================================
// Module   : tb_uart_fifo
// Brief    : Randomized self-checking bench for uart_fifo with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fifo;

    localparam int DEPTH = 512;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [9:0] level;
    logic       overflow;
    logic       clr_ovf;
`ifdef UART_FIFO_WATERMARK_EN
    logic [9:0] max_level;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue in storage, output register, in-flight flag.
    logic [7:0] q[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_fetch;
    logic       m_ovf;
    int         m_max;

    uart_fifo dut (
        .CLK      (clk),
        .RST      (rst),
        .WR_DATA  (wr_data),
        .WR_VALID (wr_valid),
        .WR_READY (wr_ready),
        .RD_DATA  (rd_data),
        .RD_VALID (rd_valid),
        .RD_READY (rd_ready),
        .LEVEL    (level),
        .OVERFLOW (overflow),
        .CLR_OVF  (clr_ovf)
`ifdef UART_FIFO_WATERMARK_EN
        ,
        .MAX_LEVEL(max_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model by the edge rules, compare #1 later.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                        input logic clr, input logic rs);
        int  pre;
        logic full;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        clr_ovf  = clr;
        rst      = rs;
        @(posedge clk);
        pre  = q.size();
        full = (pre == DEPTH);
        if (rs) begin
            q.delete();
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_fetch = 1'b0;
            m_ovf   = 1'b0;
            m_max   = 0;
        end else begin
            if (m_fetch) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
                m_fetch = 1'b0;
            end else if (m_valid) begin
                if (rr) m_valid = 1'b0;
            end else if (pre > 0) begin
                m_fetch = 1'b1;
            end
            if (wv && !full) q.push_back(wd);
            if (wv && full) m_ovf = 1'b1;
            else if (clr)   m_ovf = 1'b0;
            if (clr)              m_max = pre;
            else if (pre > m_max) m_max = pre;
        end
        #1;
        check_val("level",    32'(level),    32'(q.size()));
        check_val("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
        check_val("rd_valid", 32'(rd_valid), 32'(m_valid));
        check_val("rd_data",  32'(rd_data),  32'(m_data));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_FIFO_WATERMARK_EN
        check_val("max_level", 32'(max_level), 32'(m_max));
`endif
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rr, 1'b0, 1'b0);
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while ((q.size() != 0 || m_valid || m_fetch) && k < bound) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            k++;
        end
        if (k >= bound) check_val("drain_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0; rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("rst_level",    32'(level),    32'd0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst_rd_data",  32'(rd_data),  32'd0);
        check_val("rst_wr_ready", 32'(wr_ready), 32'd1);

        // Single-byte latency: valid after the second edge following accept.
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        check_val("lat_e0_valid", 32'(rd_valid), 32'd0);
        idle(1, 1'b0);
        check_val("lat_e1_valid", 32'(rd_valid), 32'd0);
        idle(1, 1'b0);
        check_val("lat_e2_valid", 32'(rd_valid), 32'd1);
        check_val("lat_e2_data",  32'(rd_data),  32'h41);
        check_val("lat_e2_level", 32'(level),    32'd0);
        check_val("lat_e2_ovf",   32'(overflow), 32'd0);
        drain(20);

        // Fill to full with the output stage parked.
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_val("full_level",    32'(level),    32'd512);
        check_val("full_wr_ready", 32'(wr_ready), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        check_val("full_ovf",      32'(overflow), 32'd1);
        check_val("full_level2",   32'(level),    32'd512);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            check_val("hold_data", 32'(rd_data), 32'h00);
        end
        step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
        check_val("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_val("ovf_cleared",  32'(overflow), 32'd0);
        drain(3000);

        // Streaming with wrap: 600 bytes, one per 4 cycles, reader always ready.
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
            idle(3, 1'b1);
        end
        drain(20);
        check_val("stream_ovf", 32'(overflow), 32'd0);

        // Reset with bytes stored and one held in the output register.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_val("pre_rst_level", 32'(level),    32'd5);
        check_val("pre_rst_valid", 32'(rd_valid), 32'd1);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        check_val("post_rst_level", 32'(level),    32'd0);
        check_val("post_rst_valid", 32'(rd_valid), 32'd0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_val("post_rst_data",  32'(rd_data),  32'h5A);
        drain(20);

        // Watermark scenario: 7 bytes then drain.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        drain(40);
        idle(2, 1'b0);

        // Randomized traffic with shifting write/read pressure.
        for (int i = 0; i < 3000; i++) begin
            logic wv, rr, clr, rs;
            int   phase;
            phase = (i / 500) % 3;
            wv  = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rr  = (phase == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 63) == 0);
            rs  = ($urandom_range(0, 999) == 0);
            step(wv, 8'($urandom), rr, clr, rs);
        end
        drain(3000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
